// File: rtl/key_debounce.sv
// Multi-channel push-button debouncer: 2-flop synchronizer per key, then an
// independent 4-state FSM and stability counter per channel. Debounced level
// and the press/release strobes are all registered.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE_HI | db=1, input stable high
//   CHK_LO  | db=1, input seen low, counting stability
//   IDLE_LO | db=0, input stable low (pressed)
//   CHK_HI  | db=0, input seen high, counting stability
module key_debounce #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_db,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE_HI = 2'd0,
    CHK_LO  = 2'd1,
    IDLE_LO = 2'd2,
    CHK_HI  = 2'd3
  } state_t;

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;

  state_t              r_state     [NUM_KEYS];
  state_t              w_state_nxt [NUM_KEYS];
  logic [CW-1:0]       r_cnt       [NUM_KEYS];
  logic [CW-1:0]       w_cnt_nxt   [NUM_KEYS];

  logic [NUM_KEYS-1:0] r_db;
  logic [NUM_KEYS-1:0] r_press;
  logic [NUM_KEYS-1:0] r_release;
  logic [NUM_KEYS-1:0] w_db_nxt;
  logic [NUM_KEYS-1:0] w_press_nxt;
  logic [NUM_KEYS-1:0] w_release_nxt;

  // Two-flop synchronizer; idles high so a released key reads as not pressed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  // Per-channel state, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        r_state[i] <= IDLE_HI;
        r_cnt[i]   <= '0;
      end
      r_db      <= '1;
      r_press   <= '0;
      r_release <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
      r_db      <= w_db_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  // Next-state logic; a CHK state is always left with the counter cleared,
  // so the counter can never run past DEBOUNCE_CYCLES.
  always_comb begin
    w_db_nxt      = r_db;
    w_press_nxt   = '0;
    w_release_nxt = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      case (r_state[i])
        IDLE_HI: begin
          if (!r_sync2[i]) begin
            w_state_nxt[i] = CHK_LO;
            w_cnt_nxt[i]   = CNT_ONE;
          end
        end
        CHK_LO: begin
          if (r_sync2[i]) begin
            w_state_nxt[i] = IDLE_HI;
            w_cnt_nxt[i]   = '0;
          end else if (r_cnt[i] >= CNT_MAX) begin
            w_state_nxt[i] = IDLE_LO;
            w_cnt_nxt[i]   = '0;
            w_db_nxt[i]    = 1'b0;
            w_press_nxt[i] = 1'b1;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
          end
        end
        IDLE_LO: begin
          if (r_sync2[i]) begin
            w_state_nxt[i] = CHK_HI;
            w_cnt_nxt[i]   = CNT_ONE;
          end
        end
        CHK_HI: begin
          if (!r_sync2[i]) begin
            w_state_nxt[i] = IDLE_LO;
            w_cnt_nxt[i]   = '0;
          end else if (r_cnt[i] >= CNT_MAX) begin
            w_state_nxt[i]   = IDLE_HI;
            w_cnt_nxt[i]     = '0;
            w_db_nxt[i]      = 1'b1;
            w_release_nxt[i] = 1'b1;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt[i] = IDLE_HI;
          w_cnt_nxt[i]   = '0;
        end
      endcase
    end
  end

  assign key_db      = r_db;
  assign key_press   = r_press;
  assign key_release = r_release;

endmodule
